// File: rtl/mips_ctrl_pkg.sv
// rtl/mips_ctrl_pkg.sv - opcode, aluop, mux-select and state encodings for the multicycle MIPS controller
package mips_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_ITYPE = 2'b10;
   localparam logic [1:0] ALUOP_RTYPE = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_IEXEC   = 4'd8,
      S_IWB     = 4'd9,
      S_BRANCH  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   typedef struct packed {
      logic       mem_req;
      logic       memwrite;
      logic       iord;
      logic       irwrite;
      logic       pcwrite;
      logic       branch;
      logic [1:0] pcsrc;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] aluop;
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
   } ctrl_word_t;

   function automatic logic opcode_legal(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
         OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return 1'b1;
         default:                           return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/status bundle between the controller and the datapath/memory
interface multicycle_controller_if;

   logic [5:0] opcode;
   logic       zero;
   logic       mem_ready;

   logic       mem_req;
   logic       memwrite;
   logic       iord;
   logic       irwrite;
   logic       pcwrite;
   logic       branch;
   logic [1:0] pcsrc;
   logic       alusrca;
   logic [1:0] alusrcb;
   logic [1:0] aluop;
   logic       regdst;
   logic       memtoreg;
   logic       regwrite;
   logic       illegal;

   // zero only feeds the datapath's PC-enable; the controller never looks at it
   modport master (
      input  opcode, mem_ready,
      output mem_req, memwrite, iord, irwrite, pcwrite, branch, pcsrc,
             alusrca, alusrcb, aluop, regdst, memtoreg, regwrite, illegal
   );

   modport slave (
      output opcode, zero, mem_ready,
      input  mem_req, memwrite, iord, irwrite, pcwrite, branch, pcsrc,
             alusrca, alusrcb, aluop, regdst, memtoreg, regwrite, illegal
   );

endinterface

// File: rtl/ctrl_output_decode.sv
// rtl/ctrl_output_decode.sv - combinational state (+mem_ready) to control-word decode
module ctrl_output_decode
   import mips_ctrl_pkg::*;
(
   input  state_t     state,
   input  logic       mem_ready,
   output ctrl_word_t word
);

   always_comb begin
      word = '0;
      case (state)
         S_FETCH: begin
            word.mem_req = 1'b1;
            word.alusrcb = SRCB_FOUR;
            word.aluop   = ALUOP_ADD;
            word.pcsrc   = PCSRC_ALU;
            // IR and PC+4 commit only on the cycle the fetch actually completes
            word.irwrite = mem_ready;
            word.pcwrite = mem_ready;
         end
         S_DECODE: begin
            word.alusrcb = SRCB_IMMSH;
            word.aluop   = ALUOP_ADD;
         end
         S_MEMADR: begin
            word.alusrca = 1'b1;
            word.alusrcb = SRCB_IMM;
            word.aluop   = ALUOP_ADD;
         end
         S_MEMRD: begin
            word.mem_req = 1'b1;
            word.iord    = 1'b1;
         end
         S_MEMWB: begin
            word.memtoreg = 1'b1;
            word.regwrite = 1'b1;
         end
         S_MEMWR: begin
            word.mem_req  = 1'b1;
            word.memwrite = 1'b1;
            word.iord     = 1'b1;
         end
         S_EXECUTE: begin
            word.alusrca = 1'b1;
            word.alusrcb = SRCB_REG;
            word.aluop   = ALUOP_RTYPE;
         end
         S_ALUWB: begin
            word.regdst   = 1'b1;
            word.regwrite = 1'b1;
         end
         S_IEXEC: begin
            word.alusrca = 1'b1;
            word.alusrcb = SRCB_IMM;
            word.aluop   = ALUOP_ITYPE;
         end
         S_IWB: begin
            word.regwrite = 1'b1;
         end
         S_BRANCH: begin
            word.alusrca = 1'b1;
            word.alusrcb = SRCB_REG;
            word.aluop   = ALUOP_SUB;
            word.branch  = 1'b1;
            word.pcsrc   = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            word.pcwrite = 1'b1;
            word.pcsrc   = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main sequencing FSM of the multicycle MIPS core
module multicycle_controller
   import mips_ctrl_pkg::*;
(
   input logic                     clk,
   input logic                     rst_n,
   multicycle_controller_if.master cif
);

   state_t     state;
   state_t     state_next;
   ctrl_word_t dec_word;
   ctrl_word_t word;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_next;
   end

   always_comb begin
      state_next = S_FETCH;
      case (state)
         S_FETCH:   state_next = cif.mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (cif.opcode)
               OP_LW, OP_SW:                     state_next = S_MEMADR;
               OP_RTYPE:                         state_next = S_EXECUTE;
               OP_BEQ:                           state_next = S_BRANCH;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = S_IEXEC;
               OP_J:                             state_next = S_JUMP;
               default:                          state_next = S_FETCH;
            endcase
         end
         S_MEMADR:  state_next = (cif.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_next = cif.mem_ready ? S_MEMWB : S_MEMRD;
         S_MEMWR:   state_next = cif.mem_ready ? S_FETCH : S_MEMWR;
         S_EXECUTE: state_next = S_ALUWB;
         S_IEXEC:   state_next = S_IWB;
         // MEMWB, ALUWB, IWB, BRANCH, JUMP and unused codes all return to fetch
         default:   state_next = S_FETCH;
      endcase
   end

   ctrl_output_decode u_decode (
      .state     (state),
      .mem_ready (cif.mem_ready),
      .word      (dec_word)
   );

   always_comb begin
      word         = rst_n ? dec_word : '0;
      cif.mem_req  = word.mem_req;
      cif.memwrite = word.memwrite;
      cif.iord     = word.iord;
      cif.irwrite  = word.irwrite;
      cif.pcwrite  = word.pcwrite;
      cif.branch   = word.branch;
      cif.pcsrc    = word.pcsrc;
      cif.alusrca  = word.alusrca;
      cif.alusrcb  = word.alusrcb;
      cif.aluop    = word.aluop;
      cif.regdst   = word.regdst;
      cif.memtoreg = word.memtoreg;
      cif.regwrite = word.regwrite;
      cif.illegal  = rst_n && (state == S_DECODE) && !opcode_legal(cif.opcode);
   end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller against an instruction-level model
module tb_multicycle_controller;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   multicycle_controller_if cif ();

   multicycle_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .cif   (cif.master)
   );

   typedef struct {
      logic        rdy;
      logic [16:0] exp;
      string       tag;
   } rec_t;

   rec_t exp_q[$];
   int   n_total  = 0;
   int   n_passed = 0;
   int   zero_mode = 0;   // 0 random, 1 force zero=1, 2 force zero=0

   // bit order: mem_req memwrite iord irwrite pcwrite branch pcsrc alusrca alusrcb aluop regdst memtoreg regwrite illegal
   function automatic logic [16:0] v(input logic mreq, input logic mw, input logic io, input logic irw,
                                      input logic pcw, input logic br, input logic [1:0] pcs, input logic sa,
                                      input logic [1:0] sb, input logic [1:0] aop, input logic rd,
                                      input logic m2r, input logic rw, input logic ill);
      return {mreq, mw, io, irw, pcw, br, pcs, sa, sb, aop, rd, m2r, rw, ill};
   endfunction

   function automatic logic [16:0] observed();
      return {cif.mem_req, cif.memwrite, cif.iord, cif.irwrite, cif.pcwrite, cif.branch, cif.pcsrc,
              cif.alusrca, cif.alusrcb, cif.aluop, cif.regdst, cif.memtoreg, cif.regwrite, cif.illegal};
   endfunction

   // instruction class straight from the ISA table: 0 illegal, 1 lw, 2 sw, 3 R, 4 I-type, 5 beq, 6 j
   function automatic int op_class(input logic [5:0] op);
      if (op == 6'b100011) return 1;
      if (op == 6'b101011) return 2;
      if (op == 6'b000000) return 3;
      if (op == 6'b001000 || op == 6'b001100 || op == 6'b001101 || op == 6'b001010) return 4;
      if (op == 6'b000100) return 5;
      if (op == 6'b000010) return 6;
      return 0;
   endfunction

   function automatic void push(input logic rdy, input logic [16:0] e, input string tag);
      rec_t r;
      r.rdy = rdy;
      r.exp = e;
      r.tag = tag;
      exp_q.push_back(r);
   endfunction

   // cycle-by-cycle expectation for one instruction, with fw fetch waits and mw data-access waits
   function automatic void plan(input logic [5:0] op, input int fw, input int mw, input string nm);
      int c = op_class(op);
      for (int i = 0; i < fw; i++) push(1'b0, v(1,0,0,0,0,0,2'b00,0,2'b01,2'b00,0,0,0,0), {nm, ".fetch_wait"});
      push(1'b1, v(1,0,0,1,1,0,2'b00,0,2'b01,2'b00,0,0,0,0), {nm, ".fetch"});
      push(1'($urandom), v(0,0,0,0,0,0,2'b00,0,2'b11,2'b00,0,0,0,(c == 0)), {nm, ".decode"});
      case (c)
         1: begin
            push(1'($urandom), v(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0), {nm, ".memadr"});
            for (int i = 0; i < mw; i++) push(1'b0, v(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0), {nm, ".memrd_wait"});
            push(1'b1, v(1,0,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0), {nm, ".memrd"});
            push(1'($urandom), v(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,1,1,0), {nm, ".memwb"});
         end
         2: begin
            push(1'($urandom), v(0,0,0,0,0,0,2'b00,1,2'b10,2'b00,0,0,0,0), {nm, ".memadr"});
            for (int i = 0; i < mw; i++) push(1'b0, v(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0), {nm, ".memwr_wait"});
            push(1'b1, v(1,1,1,0,0,0,2'b00,0,2'b00,2'b00,0,0,0,0), {nm, ".memwr"});
         end
         3: begin
            push(1'($urandom), v(0,0,0,0,0,0,2'b00,1,2'b00,2'b11,0,0,0,0), {nm, ".execute"});
            push(1'($urandom), v(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,1,0,1,0), {nm, ".aluwb"});
         end
         4: begin
            push(1'($urandom), v(0,0,0,0,0,0,2'b00,1,2'b10,2'b10,0,0,0,0), {nm, ".iexec"});
            push(1'($urandom), v(0,0,0,0,0,0,2'b00,0,2'b00,2'b00,0,0,1,0), {nm, ".iwb"});
         end
         5: push(1'($urandom), v(0,0,0,0,0,1,2'b01,1,2'b00,2'b01,0,0,0,0), {nm, ".branch"});
         6: push(1'($urandom), v(0,0,0,0,1,0,2'b10,0,2'b00,2'b00,0,0,0,0), {nm, ".jump"});
         default: ;
      endcase
   endfunction

   task automatic check(input logic [16:0] o, input logic [16:0] e, input string tag);
      n_total++;
      assert (o === e) n_passed++;
      else $error("FAIL %s observed=%b expected=%b", tag, o, e);
   endtask

   task automatic step(input logic rdy, input logic [16:0] e, input string tag);
      logic pcen;
      cif.mem_ready = rdy;
      cif.zero = (zero_mode == 1) ? 1'b1 : (zero_mode == 2) ? 1'b0 : 1'($urandom);
      @(negedge clk);
      check(observed(), e, tag);
      if (e[11]) begin
         pcen = cif.pcwrite | (cif.branch & cif.zero);
         n_total++;
         assert (pcen === cif.zero) n_passed++;
         else $error("FAIL %s.pcen observed=%b expected=%b", tag, pcen, cif.zero);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_plan(input int limit);
      int n = 0;
      while (exp_q.size() > 0 && n < limit) begin
         rec_t r = exp_q.pop_front();
         step(r.rdy, r.exp, r.tag);
         n++;
      end
      exp_q.delete();
   endtask

   task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input string nm);
      cif.opcode = op;
      plan(op, fw, mw, nm);
      run_plan(1000);
   endtask

   task automatic reset_cycles(input int n, input string nm);
      rst_n = 1'b0;
      for (int i = 0; i < n; i++) begin
         cif.opcode = 6'($urandom);
         step(1'($urandom), 17'd0, nm);
      end
      rst_n = 1'b1;
   endtask

   logic [5:0] ops [10] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010,
                            6'b001000, 6'b001100, 6'b001101, 6'b001010, 6'b111111};

   initial begin
      cif.opcode    = 6'd0;
      cif.zero      = 1'b0;
      cif.mem_ready = 1'b0;
      @(posedge clk);
      #1;
      reset_cycles(3, "reset");

      run_instr(6'b100011, 0, 0, "lw");
      run_instr(6'b101011, 0, 2, "sw_wait2");
      zero_mode = 1;
      run_instr(6'b000100, 0, 0, "beq_taken");
      zero_mode = 2;
      run_instr(6'b000100, 0, 0, "beq_not_taken");
      zero_mode = 0;
      run_instr(6'b001101, 1, 0, "ori");
      run_instr(6'b000000, 0, 0, "rtype");
      run_instr(6'b000010, 0, 0, "j");
      run_instr(6'b111111, 0, 0, "illegal");

      // reset while MEMRD is stalled: the load is dropped and the next cycle is a fresh fetch
      cif.opcode = 6'b100011;
      plan(6'b100011, 0, 5, "lw_abort");
      run_plan(5);
      reset_cycles(2, "reset_mid_memrd");
      run_instr(6'b001000, 0, 0, "addi_after_reset");

      for (int k = 0; k < 60; k++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : ops[$urandom_range(0, 9)];
         run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), $sformatf("rnd%0d_op%b", k, op));
      end

      $display("%0d/%0d checks passed", n_passed, n_total);
      $finish;
   end

endmodule
